sfr_rmw_ctrl: RTL
=================

# sfr_rmw_ctrl

Sequencer that sits directly upstream of the SFR register file and owns its access port (address, data, write strobes). It accepts one SFR request at a time from the core's execute stage (byte read/write, byte read-modify-write, bit read/write/complement, jump-if-bit-and-clear). It turns each request into correctly timed read and write cycles, given that the register file's read data is registered with one cycle of latency. It returns the read or result value to the execute stage with a single-cycle response pulse.

## Interface
- No parameters; opcode and SFR encodings come from the shared define file.
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; transfer occurs when req_valid && req_ready.
- req_op  in  4  operation: 0 NOP, 1 RD, 2 WR, 3 ANL, 4 ORL, 5 XRL, 6 INC, 7 DEC, 8 RDBIT, 9 SETB, 10 CLRB, 11 CPLB, 12 MOVB, 13 JBC; 14–15 illegal.
- req_addr  in  8  byte address (ops 1–7) or bit address (ops 8–13).
- req_data  in  8  operand for WR/ANL/ORL/XRL.
- req_bit  in  1  operand for MOVB.
- resp_valid  out  1  one-cycle pulse; no back-pressure.
- resp_data  out  8  RD: value read; ALU ops: value written; others 0.
- resp_bit  out  1  RDBIT/CPLB/JBC: original bit value; others 0.
- resp_err  out  1  illegal op, NOP, or bit address < 0x80.
- sfr_addr  out  8  to register file addr.
- sfr_data_in  out  8  to register file data_in.
- sfr_bit_in  out  1  to register file bit_in.
- sfr_write_en  out  1  byte write strobe.
- sfr_write_bit_en  out  1  bit write strobe.
- sfr_data_out  in  8  register file data_out (valid the cycle after sfr_addr is presented).

## Operation
- States: IDLE, READ, EVAL, WRITE, DONE.
- IDLE: accepting a request latches op, addr, data and bit. Next state is WRITE for WR/SETB/CLRB/MOVB, READ for RD/ALU ops/RDBIT/CPLB/JBC, and DONE with err=1 for NOP, illegal ops, or bit ops with addr[7] = 0.
- READ: drive sfr_addr = byte address. For bit ops the byte address is {addr[7:3],3'b000}. Go to EVAL.
- EVAL: sample sfr_data_out and compute the result in the ALU sub-module.
  - ANL/ORL/XRL: bitwise op with req_data.
  - INC/DEC: 8-bit modulo (0xFF+1 = 0x00, 0x00−1 = 0xFF).
  - RDBIT: bit = data[addr[2:0]].
  - RD and RDBIT go to DONE.
  - JBC with bit = 0 goes to DONE with no write.
  - Everything else goes to WRITE.
- WRITE: hold strobes for exactly one cycle, then go to DONE.
  - Byte ops: sfr_addr = byte address, sfr_data_in = result, sfr_write_en = 1.
  - Bit ops: sfr_addr = bit address, sfr_bit_in = new bit, sfr_write_bit_en = 1. New bit is 1 for SETB, 0 for CLRB and JBC, ~old for CPLB, req_bit for MOVB.
- DONE: assert resp_valid with resp_* valid, then go to IDLE.
- sfr_write_en and sfr_write_bit_en are never both high. Both are 0 outside WRITE.
- sfr_addr holds its last value outside READ/WRITE. sfr_data_in and sfr_bit_in are 0 outside WRITE.

## Timing
- Reset: state IDLE; every output 0 except req_ready = 1.
- Accept occurs in cycle 0.
- Latencies, counted from accept to the resp_valid cycle:
  - WR/SETB/CLRB/MOVB: 2 cycles.
  - RD/RDBIT: 3 cycles.
  - JBC with bit clear: 3 cycles.
  - ALU ops, CPLB, JBC with bit set: 4 cycles.
  - Errors: 1 cycle.
- Back-to-back: req_ready rises in the cycle after DONE. A new request can be accepted at the earliest one cycle after resp_valid.
- Reset asserted mid-operation: immediate return to IDLE. Strobes drop asynchronously, no partial write completes, and no resp_valid is issued.
- req_* inputs are ignored outside IDLE.

## Structure
- Opcode values and state encodings are `define constants in the shared SFR define file, next to the SFR_* address macros.
- One combinational sub-module, sfr_rmw_alu, takes op, old byte, operand byte, bit index and operand bit. It outputs the new byte, the old bit and the new bit.
- Top level contains the FSM, request latches and output registers.

## Test plan
- WR 0xE0 data 0x5A: in cycle 1, sfr_addr = 0xE0, sfr_data_in = 0x5A, sfr_write_en = 1. In cycle 2, resp_valid = 1 with err = 0.
- INC 0xF0 with B = 0xFF: READ, then EVAL, then WRITE of 0x00 to 0xF0; resp_data = 0x00 in cycle 4. DEC with B = 0x00 writes 0xFF.
- CPLB 0x93 with P1 = 0x08: read 0x90; bit write in cycle 3 with sfr_addr = 0x93, sfr_bit_in = 0, sfr_write_bit_en = 1; resp_bit = 1.
- JBC 0xE0 with ACC = 0x00: no write strobe at any point; resp_bit = 0 in cycle 3. With ACC = 0x01: clear-bit write, resp_bit = 1 in cycle 4.
- Errors: SETB 0x20, op 15 and NOP each give resp_err = 1 in cycle 1 with no strobes.
- Reset asserted in the EVAL cycle of ORL 0xD0: no write_en pulse, no resp_valid, req_ready = 1 after release; the next WR completes normally.

Source files
------------

// File: rtl/sfr_rmw_ctrl_pkg.sv
// Shared opcode encodings, state encoding and decode helpers for the SFR
// read-modify-write sequencer.
package sfr_rmw_ctrl_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned BIDX_W = 3;

    localparam logic [OP_W-1:0] OP_NOP   = 4'd0;
    localparam logic [OP_W-1:0] OP_RD    = 4'd1;
    localparam logic [OP_W-1:0] OP_WR    = 4'd2;
    localparam logic [OP_W-1:0] OP_ANL   = 4'd3;
    localparam logic [OP_W-1:0] OP_ORL   = 4'd4;
    localparam logic [OP_W-1:0] OP_XRL   = 4'd5;
    localparam logic [OP_W-1:0] OP_INC   = 4'd6;
    localparam logic [OP_W-1:0] OP_DEC   = 4'd7;
    localparam logic [OP_W-1:0] OP_RDBIT = 4'd8;
    localparam logic [OP_W-1:0] OP_SETB  = 4'd9;
    localparam logic [OP_W-1:0] OP_CLRB  = 4'd10;
    localparam logic [OP_W-1:0] OP_CPLB  = 4'd11;
    localparam logic [OP_W-1:0] OP_MOVB  = 4'd12;
    localparam logic [OP_W-1:0] OP_JBC   = 4'd13;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_EVAL  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic logic op_is_bit(input logic [OP_W-1:0] op);
        return (op >= OP_RDBIT) && (op <= OP_JBC);
    endfunction

    // Ops whose result is a byte written back (and returned as resp_data).
    function automatic logic op_is_byte_write(input logic [OP_W-1:0] op);
        return (op >= OP_WR) && (op <= OP_DEC);
    endfunction

    // Bit writes that need no prior read.
    function automatic logic op_is_blind_bit(input logic [OP_W-1:0] op);
        return (op == OP_SETB) || (op == OP_CLRB) || (op == OP_MOVB);
    endfunction

    // Bit ops only address the bit-addressable SFRs (0x80 and above).
    function automatic logic op_is_err(input logic [OP_W-1:0] op,
                                       input logic [ADDR_W-1:0] addr);
        return (op == OP_NOP) || (op > OP_JBC) || (op_is_bit(op) && !addr[ADDR_W-1]);
    endfunction

    function automatic logic new_bit_f(input logic [OP_W-1:0] op,
                                       input logic old_bit,
                                       input logic operand_bit);
        logic nb;
        case (op)
            OP_SETB:        nb = 1'b1;
            OP_CLRB,
            OP_JBC:         nb = 1'b0;
            OP_CPLB:        nb = ~old_bit;
            OP_MOVB:        nb = operand_bit;
            default:        nb = old_bit;
        endcase
        return nb;
    endfunction

endpackage

// File: rtl/sfr_rmw_alu.sv
// Combinational result path: new byte for byte ops, old/new bit for bit ops.
module sfr_rmw_alu
    import sfr_rmw_ctrl_pkg::*;
(
    input  logic [OP_W-1:0]   op_i,
    input  logic [DATA_W-1:0] old_byte_i,
    input  logic [DATA_W-1:0] operand_i,
    input  logic [BIDX_W-1:0] bit_idx_i,
    input  logic              operand_bit_i,
    output logic [DATA_W-1:0] new_byte_c_o,
    output logic              old_bit_c_o,
    output logic              new_bit_c_o
);

    always_comb begin
        new_byte_c_o = old_byte_i;
        case (op_i)
            OP_WR:   new_byte_c_o = operand_i;
            OP_ANL:  new_byte_c_o = old_byte_i & operand_i;
            OP_ORL:  new_byte_c_o = old_byte_i | operand_i;
            OP_XRL:  new_byte_c_o = old_byte_i ^ operand_i;
            OP_INC:  new_byte_c_o = old_byte_i + DATA_W'(1);
            OP_DEC:  new_byte_c_o = old_byte_i - DATA_W'(1);
            default: new_byte_c_o = old_byte_i;
        endcase
    end

    assign old_bit_c_o = old_byte_i[bit_idx_i];
    assign new_bit_c_o = new_bit_f(op_i, old_bit_c_o, operand_bit_i);

endmodule

// File: rtl/sfr_rmw_ctrl.sv
// SFR access sequencer: turns one execute-stage request into timed read and
// write cycles on the register-file port and returns a one-cycle response.
module sfr_rmw_ctrl
    import sfr_rmw_ctrl_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic              req_bit,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_bit,
    output logic              resp_err,
    output logic [ADDR_W-1:0] sfr_addr,
    output logic [DATA_W-1:0] sfr_data_in,
    output logic              sfr_bit_in,
    output logic              sfr_write_en,
    output logic              sfr_write_bit_en,
    input  logic [DATA_W-1:0] sfr_data_out
);

    state_e            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              bit_q, bit_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              old_bit_q, old_bit_d;

    logic              ready_q, ready_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rbit_q, rbit_d;
    logic              rerr_q, rerr_d;
    logic [ADDR_W-1:0] saddr_q, saddr_d;
    logic [DATA_W-1:0] sdin_q, sdin_d;
    logic              sbin_q, sbin_d;
    logic              swe_q, swe_d;
    logic              swbe_q, swbe_d;

    logic [DATA_W-1:0] alu_byte;
    logic              alu_old_bit;
    logic              alu_new_bit;

    sfr_rmw_alu u_alu (
        .op_i          (op_q),
        .old_byte_i    (sfr_data_out),
        .operand_i     (data_q),
        .bit_idx_i     (addr_q[BIDX_W-1:0]),
        .operand_bit_i (bit_q),
        .new_byte_c_o  (alu_byte),
        .old_bit_c_o   (alu_old_bit),
        .new_bit_c_o   (alu_new_bit)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            bit_q     <= 1'b0;
            result_q  <= '0;
            old_bit_q <= 1'b0;
            ready_q   <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rbit_q    <= 1'b0;
            rerr_q    <= 1'b0;
            saddr_q   <= '0;
            sdin_q    <= '0;
            sbin_q    <= 1'b0;
            swe_q     <= 1'b0;
            swbe_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            bit_q     <= bit_d;
            result_q  <= result_d;
            old_bit_q <= old_bit_d;
            ready_q   <= ready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rbit_q    <= rbit_d;
            rerr_q    <= rerr_d;
            saddr_q   <= saddr_d;
            sdin_q    <= sdin_d;
            sbin_q    <= sbin_d;
            swe_q     <= swe_d;
            swbe_q    <= swbe_d;
        end
    end

    // Outputs are registered, so each transition loads the values for the next state.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        data_d    = data_q;
        bit_d     = bit_q;
        result_d  = result_q;
        old_bit_d = old_bit_q;
        ready_d   = 1'b0;
        rvalid_d  = 1'b0;
        rdata_d   = '0;
        rbit_d    = 1'b0;
        rerr_d    = 1'b0;
        saddr_d   = saddr_q;
        sdin_d    = '0;
        sbin_d    = 1'b0;
        swe_d     = 1'b0;
        swbe_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (req_valid) begin
                    ready_d  = 1'b0;
                    op_d     = req_op;
                    addr_d   = req_addr;
                    data_d   = req_data;
                    bit_d    = req_bit;
                    result_d = req_data;
                    if (op_is_err(req_op, req_addr)) begin
                        state_d  = ST_DONE;
                        rvalid_d = 1'b1;
                        rerr_d   = 1'b1;
                    end else if (req_op == OP_WR) begin
                        state_d = ST_WRITE;
                        saddr_d = req_addr;
                        sdin_d  = req_data;
                        swe_d   = 1'b1;
                    end else if (op_is_blind_bit(req_op)) begin
                        state_d = ST_WRITE;
                        saddr_d = req_addr;
                        sbin_d  = new_bit_f(req_op, 1'b0, req_bit);
                        swbe_d  = 1'b1;
                    end else begin
                        state_d = ST_READ;
                        saddr_d = op_is_bit(req_op)
                                ? {req_addr[ADDR_W-1:BIDX_W], BIDX_W'(0)}
                                : req_addr;
                    end
                end
            end
            ST_READ: begin
                state_d = ST_EVAL;
            end
            ST_EVAL: begin
                result_d  = alu_byte;
                old_bit_d = alu_old_bit;
                if (op_q == OP_RD) begin
                    state_d  = ST_DONE;
                    rvalid_d = 1'b1;
                    rdata_d  = sfr_data_out;
                end else if ((op_q == OP_RDBIT) || ((op_q == OP_JBC) && !alu_old_bit)) begin
                    state_d  = ST_DONE;
                    rvalid_d = 1'b1;
                    rbit_d   = alu_old_bit;
                end else if (op_is_bit(op_q)) begin
                    state_d = ST_WRITE;
                    saddr_d = addr_q;
                    sbin_d  = alu_new_bit;
                    swbe_d  = 1'b1;
                end else begin
                    state_d = ST_WRITE;
                    saddr_d = addr_q;
                    sdin_d  = alu_byte;
                    swe_d   = 1'b1;
                end
            end
            ST_WRITE: begin
                state_d  = ST_DONE;
                rvalid_d = 1'b1;
                rdata_d  = op_is_byte_write(op_q) ? result_q : '0;
                rbit_d   = ((op_q == OP_CPLB) || (op_q == OP_JBC)) ? old_bit_q : 1'b0;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    assign req_ready        = ready_q;
    assign resp_valid       = rvalid_q;
    assign resp_data        = rdata_q;
    assign resp_bit         = rbit_q;
    assign resp_err         = rerr_q;
    assign sfr_addr         = saddr_q;
    assign sfr_data_in      = sdin_q;
    assign sfr_bit_in       = sbin_q;
    assign sfr_write_en     = swe_q;
    assign sfr_write_bit_en = swbe_q;

endmodule
